// File: rtl/fft_pkg.sv
// Shared FFT stage definitions: stage phases, the wide complex accumulator, twiddle
// generation and the fixed-point round/saturate helper used by the twiddle multiplier.
package fft_pkg;

  localparam int  ACC_W = 48;
  localparam real PI    = 3.14159265358979323846;

  typedef enum logic {
    PH_FILL = 1'b0,
    PH_BFLY = 1'b1
  } phase_t;

  typedef struct packed {
    logic signed [ACC_W-1:0] re;
    logic signed [ACC_W-1:0] im;
  } cplx_acc_t;

  // Quantise a unit-range real to signed Q1.(tw_w-1); +1.0 clamps to the largest code.
  function automatic int tw_q(input real x, input int tw_w);
    real scaled;
    int  q;
    int  lim;
    lim    = (1 << (tw_w - 1)) - 1;
    scaled = x * real'(1 << (tw_w - 1));
    if (scaled >= 0.0) q = $rtoi(scaled + 0.5);
    else               q = -$rtoi(0.5 - scaled);
    if (q > lim) q = lim;
    return q;
  endfunction

  function automatic int tw_cos(input int k, input int d, input int tw_w);
    return tw_q($cos(PI * real'(k) / real'(d)), tw_w);
  endfunction

  function automatic int tw_sin(input int k, input int d, input int tw_w);
    return tw_q($sin(PI * real'(k) / real'(d)), tw_w);
  endfunction

  // Round half up by adding 2^(frac-1) before the arithmetic shift, then clamp to out_w bits.
  function automatic logic signed [ACC_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] acc,
    input int                      frac,
    input int                      out_w
  );
    logic signed [ACC_W-1:0] one;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    one = ACC_W'(1);
    rnd = (acc + (one <<< (frac - 1))) >>> frac;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -hi - one;
    if (rnd > hi)      return hi;
    else if (rnd < lo) return lo;
    return rnd;
  endfunction

endpackage

// File: rtl/cmul_tw.sv
// Complex multiply by W_2D^k = cos(pi*k/D) - j*sin(pi*k/D) with round-half-up and
// saturation; k=0 and k=D/2 use exact bypass and -j paths instead of the multiplier.
module cmul_tw
  import fft_pkg::*;
#(
  parameter int W     = 16,
  parameter int TW_W  = 12,
  parameter int DEPTH = 4,
  localparam int K_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [K_W-1:0]      k,
  input  logic signed [W-1:0] in_r,
  input  logic signed [W-1:0] in_i,
  output logic signed [W-1:0] out_r,
  output logic signed [W-1:0] out_i
);

  localparam logic signed [W-1:0] MAX_V  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};
  localparam logic [K_W-1:0]      K_HALF = K_W'(DEPTH / 2);

  logic signed [W-1:0] mul_r;
  logic signed [W-1:0] mul_i;
  logic signed [W-1:0] negj_r;
  logic signed [W-1:0] negj_i;

  // Multiplying by -j swaps components; negating the most negative code must saturate.
  always_comb begin
    negj_r = in_i;
    negj_i = (in_r == MIN_V) ? MAX_V : -in_r;
  end

  generate
    if (DEPTH > 2) begin : g_mult
      logic signed [TW_W-1:0] cos_rom [DEPTH];
      logic signed [TW_W-1:0] sin_rom [DEPTH];
      logic signed [TW_W-1:0] c;
      logic signed [TW_W-1:0] s;
      cplx_acc_t              acc;

      for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign cos_rom[g] = TW_W'(tw_cos(g, DEPTH, TW_W));
        assign sin_rom[g] = TW_W'(tw_sin(g, DEPTH, TW_W));
      end

      // (r + j i)(c - j s) = (r c + i s) + j (i c - r s)
      always_comb begin
        c      = cos_rom[k];
        s      = sin_rom[k];
        acc.re = ACC_W'(in_r) * ACC_W'(c) + ACC_W'(in_i) * ACC_W'(s);
        acc.im = ACC_W'(in_i) * ACC_W'(c) - ACC_W'(in_r) * ACC_W'(s);
        mul_r  = W'(round_sat(acc.re, TW_W - 1, W));
        mul_i  = W'(round_sat(acc.im, TW_W - 1, W));
      end
    end else begin : g_nomult
      assign mul_r = in_r;
      assign mul_i = in_i;
    end
  endgenerate

  always_comb begin
    if (k == '0) begin
      out_r = in_r;
      out_i = in_i;
    end else if (DEPTH >= 2 && k == K_HALF) begin
      out_r = negj_r;
      out_i = negj_i;
    end else begin
      out_r = mul_r;
      out_i = mul_i;
    end
  end

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback DIF FFT stage: butterfly, D-deep feedback delay
// line and twiddle multiply on the difference path; the output word grows by one bit.
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int DEPTH = 4,
  parameter int TW_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  input  logic                   sof_i,
  input  logic signed [IN_W-1:0] data_in_r,
  input  logic signed [IN_W-1:0] data_in_i,
  output logic                   valid_o,
  output logic                   sof_o,
  output logic signed [IN_W:0]   data_out_r,
  output logic signed [IN_W:0]   data_out_i
);

  localparam int OUT_W = IN_W + 1;
  localparam int CNT_W = $clog2(2 * DEPTH);
  localparam int K_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_SOF  = CNT_W'(DEPTH);

  logic                   in_valid_q;
  logic                   in_sof_q;
  logic signed [IN_W-1:0] in_r_q;
  logic signed [IN_W-1:0] in_i_q;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cur;
  logic             primed;
  phase_t           phase;
  logic [K_W-1:0]   k;
  logic             emit;

  logic signed [OUT_W-1:0] dl_r [DEPTH];
  logic signed [OUT_W-1:0] dl_i [DEPTH];

  logic signed [OUT_W-1:0] b_r;
  logic signed [OUT_W-1:0] b_i;
  logic signed [OUT_W-1:0] head_r;
  logic signed [OUT_W-1:0] head_i;
  logic signed [OUT_W-1:0] push_r;
  logic signed [OUT_W-1:0] push_i;
  logic signed [OUT_W-1:0] tw_r;
  logic signed [OUT_W-1:0] tw_i;
  logic signed [OUT_W-1:0] res_r;
  logic signed [OUT_W-1:0] res_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_sof_q   <= 1'b0;
      in_r_q     <= '0;
      in_i_q     <= '0;
    end else begin
      in_valid_q <= valid_i;
      in_sof_q   <= sof_i & valid_i;
      in_r_q     <= data_in_r;
      in_i_q     <= data_in_i;
    end
  end

  // A start-of-frame sample is forced to slot 0; the slot MSB separates FILL from BFLY.
  always_comb begin
    cur    = in_sof_q ? '0 : cnt;
    phase  = phase_t'(cur[CNT_W-1]);
    k      = K_W'(cur % DEPTH);
    emit   = (phase == PH_BFLY) || primed;
    b_r    = OUT_W'(in_r_q);
    b_i    = OUT_W'(in_i_q);
    head_r = dl_r[DEPTH-1];
    head_i = dl_i[DEPTH-1];
    if (phase == PH_FILL) begin
      push_r = b_r;
      push_i = b_i;
      res_r  = tw_r;
      res_i  = tw_i;
    end else begin
      push_r = head_r - b_r;
      push_i = head_i - b_i;
      res_r  = head_r + b_r;
      res_i  = head_i + b_i;
    end
  end

  cmul_tw #(
    .W     (OUT_W),
    .TW_W  (TW_W),
    .DEPTH (DEPTH)
  ) u_cmul_tw (
    .k     (k),
    .in_r  (head_r),
    .in_i  (head_i),
    .out_r (tw_r),
    .out_i (tw_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid_q) begin
      cnt <= cur + CNT_W'(1);
      if (cur == CNT_LAST) primed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        dl_r[n] <= '0;
        dl_i[n] <= '0;
      end
    end else if (in_valid_q) begin
      dl_r[0] <= push_r;
      dl_i[0] <= push_i;
      for (int n = 1; n < DEPTH; n++) begin
        dl_r[n] <= dl_r[n-1];
        dl_i[n] <= dl_i[n-1];
      end
    end
  end

  // Output data holds its last value whenever no sample is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      sof_o      <= 1'b0;
      data_out_r <= '0;
      data_out_i <= '0;
    end else begin
      valid_o <= in_valid_q && emit;
      sof_o   <= in_valid_q && (cur == CNT_SOF);
      if (in_valid_q && emit) begin
        data_out_r <= res_r;
        data_out_i <= res_i;
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Randomised and directed bench for sdf_r2_stage against a queue-based model of the
// delay-feedback butterfly, with literal expectations for the hand-worked frames.
module tb_sdf_r2_stage;

  localparam int  IN_W  = 15;
  localparam int  DEPTH = 4;
  localparam int  TW_W  = 12;
  localparam int  OUT_W = IN_W + 1;
  localparam int  FLEN  = 2 * DEPTH;
  localparam real PI    = 3.14159265358979323846;

  typedef struct {
    bit vld;
    bit sof;
    int r;
    int i;
  } exp_t;

  typedef struct {
    int r;
    int i;
    bit sof;
  } smp_t;

  logic                    clk       = 1'b0;
  logic                    rst_n     = 1'b0;
  logic                    valid_i   = 1'b0;
  logic                    sof_i     = 1'b0;
  logic signed [IN_W-1:0]  data_in_r = '0;
  logic signed [IN_W-1:0]  data_in_i = '0;
  logic                    valid_o;
  logic                    sof_o;
  logic signed [OUT_W-1:0] data_out_r;
  logic signed [OUT_W-1:0] data_out_i;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t expm [int];
  exp_t mon_e;
  smp_t got [$];
  int   mq_r [$];
  int   mq_i [$];
  int   m_next;
  bit   m_primed;
  int   f1 [FLEN];
  int   f2 [FLEN];
  int   fz [FLEN];

  sdf_r2_stage #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH),
    .TW_W  (TW_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .sof_i      (sof_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .sof_o      (sof_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int satOut(input longint v);
    longint lim;
    lim = longint'(1) <<< (OUT_W - 1);
    if (v > lim - 1) return int'(lim - 1);
    if (v < -lim)    return int'(-lim);
    return int'(v);
  endfunction

  // Multiply by W_2D^k = cos(pi k/D) - j sin(pi k/D) in Q1.(TW_W-1), round half up.
  task automatic twiddleModel(input int hr, input int hi, input int k,
                              output int tr, output int ti);
    real    ang;
    longint c, s, pr, pim, half;
    if (k == 0) begin
      tr = hr;
      ti = hi;
    end else if (k == DEPTH / 2) begin
      tr = hi;
      ti = satOut(-longint'(hr));
    end else begin
      ang  = PI * real'(k) / real'(DEPTH);
      c    = longint'($cos(ang) * real'(1 << (TW_W - 1)));
      s    = longint'($sin(ang) * real'(1 << (TW_W - 1)));
      half = longint'(1) <<< (TW_W - 2);
      pr   = longint'(hr) * c + longint'(hi) * s;
      pim  = longint'(hi) * c - longint'(hr) * s;
      tr   = satOut((pr + half) >>> (TW_W - 1));
      ti   = satOut((pim + half) >>> (TW_W - 1));
    end
  endtask

  task automatic modelReset();
    mq_r.delete();
    mq_i.delete();
    for (int n = 0; n < DEPTH; n++) begin
      mq_r.push_back(0);
      mq_i.push_back(0);
    end
    m_next   = 0;
    m_primed = 0;
    expm.delete();
  endtask

  task automatic modelStep(input bit s, input int xr, input int xi, output exp_t e);
    int cur, hr, hi, tr, ti;
    cur = s ? 0 : m_next;
    hr  = mq_r.pop_front();
    hi  = mq_i.pop_front();
    if (cur >= DEPTH) begin
      e.r   = hr + xr;
      e.i   = hi + xi;
      e.vld = 1'b1;
      mq_r.push_back(hr - xr);
      mq_i.push_back(hi - xi);
    end else begin
      twiddleModel(hr, hi, cur % DEPTH, tr, ti);
      e.r   = tr;
      e.i   = ti;
      e.vld = m_primed;
      mq_r.push_back(xr);
      mq_i.push_back(xi);
    end
    e.sof = (cur == DEPTH);
    if (cur == FLEN - 1) m_primed = 1'b1;
    m_next = (cur + 1) % FLEN;
  endtask

  // Output for a sample driven now becomes visible two clock edges later.
  task automatic applyStimulus(input bit v, input bit s, input int r, input int i);
    exp_t e;
    @(negedge clk);
    #1;
    valid_i   = v;
    sof_i     = s;
    data_in_r = IN_W'(r);
    data_in_i = IN_W'(i);
    if (v) begin
      modelStep(s, r, i, e);
      if (e.vld) expm[cyc + 2] = e;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++)
      applyStimulus(1'b0, 1'b0, int'($urandom_range(0, 32767)) - 16384,
                    int'($urandom_range(0, 32767)) - 16384);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("reset valid_o", int'(valid_o), 0);
    checkOutput("reset sof_o", int'(sof_o), 0);
    checkOutput("reset data_out_r", int'(data_out_r), 0);
    checkOutput("reset data_out_i", int'(data_out_i), 0);
    got.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic sendFrame(input int v [FLEN], input int gapMode);
    for (int j = 0; j < FLEN; j++) begin
      if (gapMode == 2) idle(int'($urandom_range(0, 3)));
      applyStimulus(1'b1, j == 0, v[j], 0);
      if (gapMode == 1) idle(1);
    end
  endtask

  task automatic checkGot(input string name, input int idx, input int er, input int ei,
                          input int es);
    if (idx >= got.size()) begin
      checkOutput({name, " present"}, got.size(), idx + 1);
    end else begin
      checkOutput({name, " re"}, got[idx].r, er);
      checkOutput({name, " im"}, got[idx].i, ei);
      checkOutput({name, " sof"}, int'(got[idx].sof), es);
    end
  endtask

  always @(negedge clk) begin
    mon_e = '{vld: 1'b0, sof: 1'b0, r: 0, i: 0};
    if (expm.exists(cyc)) begin
      mon_e = expm[cyc];
      expm.delete(cyc);
    end
    checkOutput("valid_o", int'(valid_o), int'(mon_e.vld));
    checkOutput("sof_o", int'(sof_o), int'(mon_e.vld & mon_e.sof));
    if (mon_e.vld) begin
      checkOutput("data_out_r", int'(data_out_r), mon_e.r);
      checkOutput("data_out_i", int'(data_out_i), mon_e.i);
    end
    if (valid_o === 1'b1)
      got.push_back('{r: int'(data_out_r), i: int'(data_out_i), sof: sof_o});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    for (int j = 0; j < FLEN; j++) fz[j] = 0;

    // Impulse frame twice: sums, then the bypassed difference in the next FILL.
    for (int j = 0; j < FLEN; j++) f1[j] = (j == 0) ? 1000 : 0;
    doReset();
    sendFrame(f1, 0);
    sendFrame(f1, 0);
    idle(4);
    checkOutput("t1 count", got.size(), 12);
    checkGot("t1 sum0", 0, 1000, 0, 1);
    checkGot("t1 sum1", 1, 0, 0, 0);
    checkGot("t1 fill0", 4, 1000, 0, 0);
    checkGot("t1 fill1", 5, 0, 0, 0);
    checkGot("t1 sum0b", 8, 1000, 0, 1);

    for (int j = 0; j < FLEN; j++) f2[j] = 100;
    doReset();
    sendFrame(f2, 0);
    sendFrame(f2, 0);
    idle(4);
    checkGot("t2 sum0", 0, 200, 0, 1);
    checkGot("t2 sum3", 3, 200, 0, 0);
    checkGot("t2 fill0", 4, 0, 0, 0);
    checkGot("t2 fill3", 7, 0, 0, 0);
    checkGot("t2 sum0b", 8, 200, 0, 1);

    // Twiddled differences: k=1 goes through the multiplier, k=2 is the exact -j path.
    for (int j = 0; j < FLEN; j++) f2[j] = (j == 1) ? 1000 : ((j == 2) ? 500 : 0);
    doReset();
    sendFrame(f2, 0);
    sendFrame(fz, 0);
    idle(4);
    checkGot("t3 sum1", 1, 1000, 0, 0);
    checkGot("t3 sum2", 2, 500, 0, 0);
    checkGot("t3 fill0", 4, 0, 0, 0);
    checkGot("t3 fill k1", 5, 707, -707, 0);
    checkGot("t3 fill k2", 6, 0, -500, 0);

    for (int j = 0; j < FLEN; j++) f2[j] = (j == 0 || j == DEPTH) ? 16383 : 0;
    doReset();
    sendFrame(f2, 0);
    for (int j = 0; j < FLEN; j++) f2[j] = (j == 0) ? -16384 : ((j == DEPTH) ? 16383 : 0);
    sendFrame(f2, 0);
    sendFrame(fz, 0);
    idle(4);
    checkGot("t4 max sum", 0, 32766, 0, 1);
    checkGot("t4 mixed sum", 8, -1, 0, 1);
    checkGot("t4 min diff", 12, -32767, 0, 0);

    // Same impulse frames with regular and random input gaps.
    doReset();
    sendFrame(f1, 1);
    sendFrame(f1, 2);
    idle(6);
    checkOutput("t5 count", got.size(), 12);
    checkGot("t5 sum0", 0, 1000, 0, 1);
    checkGot("t5 fill0", 4, 1000, 0, 0);
    checkGot("t5 sum0b", 8, 1000, 0, 1);

    // Reset mid-frame, then realign on a start-of-frame at slot 5.
    doReset();
    for (int j = 0; j < 3; j++)
      applyStimulus(1'b1, j == 0, int'($urandom_range(0, 32767)) - 16384,
                    int'($urandom_range(0, 32767)) - 16384);
    doReset();
    for (int j = 0; j < 13; j++)
      applyStimulus(1'b1, j == 5, int'($urandom_range(0, 32767)) - 16384,
                    int'($urandom_range(0, 32767)) - 16384);
    idle(4);
    checkOutput("t6 count", got.size(), 5);
    if (got.size() >= 2) begin
      checkOutput("t6 first sof", int'(got[0].sof), 1);
      checkOutput("t6 realigned sof", int'(got[1].sof), 1);
    end

    doReset();
    for (int n = 0; n < 1200; n++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 39) == 0);
      applyStimulus(v, s, int'($urandom_range(0, 32767)) - 16384,
                    int'($urandom_range(0, 32767)) - 16384);
      if (n == 600) doReset();
    end
    idle(4);
    checkOutput("pending outputs drained", expm.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
